// File: rtl/data_memory_if.sv
// Load/store bus between the MIPS memory stage and the data memory.
// The master drives address, store data and enables; the slave returns load data.
interface data_memory_if;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData;

    modport master (
        output address,
        output writeData,
        output memWrite,
        output memRead,
        input  readData
    );

    modport slave (
        input  address,
        input  writeData,
        input  memWrite,
        input  memRead,
        output readData
    );
endinterface

// File: rtl/data_memory.sv
// Word-organised data memory: zero-wait backing RAM fronted by a direct-mapped,
// write-through, write-allocate cache that is transparent to the datapath.
module data_memory #(
    parameter int MEM_WORDS_LOG2 = 8,
    parameter int INDEX_BITS     = 4
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);
    localparam int WORDS    = 1 << MEM_WORDS_LOG2;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = MEM_WORDS_LOG2 - INDEX_BITS;

    logic [31:0]               ram_q   [WORDS];
    logic [LINES-1:0]          valid_q;
    logic [TAG_BITS-1:0]       tag_q   [LINES];
    logic [31:0]               data_q  [LINES];

    logic [MEM_WORDS_LOG2-1:0] word_idx;
    logic [INDEX_BITS-1:0]     line_idx;
    logic [TAG_BITS-1:0]       addr_tag;
    logic                      hit;
    logic                      line_we;
    logic [31:0]               line_data_d;
    logic [31:0]               read_data;

    // Byte offset and bits above the RAM range are don't-care, so addresses alias.
    logic unused_addr;
    assign unused_addr = ^{bus.address[31:MEM_WORDS_LOG2+2], bus.address[1:0]};

    assign word_idx = bus.address[MEM_WORDS_LOG2+1:2];
    assign line_idx = bus.address[INDEX_BITS+1:2];
    assign addr_tag = bus.address[MEM_WORDS_LOG2+1:INDEX_BITS+2];
    assign hit      = valid_q[line_idx] && (tag_q[line_idx] == addr_tag);

    // A store always allocates; a load only refills on a miss. Store data wins over refill.
    always_comb begin
        line_we     = 1'b0;
        line_data_d = ram_q[word_idx];
        if (bus.memWrite) begin
            line_we     = 1'b1;
            line_data_d = bus.writeData;
        end else if (bus.memRead && !hit) begin
            line_we     = 1'b1;
        end
    end

    always_comb begin
        read_data = '0;
        if (!rst && bus.memRead) begin
            read_data = hit ? data_q[line_idx] : ram_q[word_idx];
        end
    end
    assign bus.readData = read_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < WORDS; k++) begin
                ram_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            if (bus.memWrite) begin
                ram_q[word_idx] <= bus.writeData;
            end
            if (line_we) begin
                valid_q[line_idx] <= 1'b1;
            end
        end
    end

    // Tag and data payload need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && line_we) begin
            tag_q[line_idx]  <= addr_tag;
            data_q[line_idx] <= line_data_d;
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Directed-vector bench for data_memory with a queue-based scoreboard and
// an independent monitor sampling on the falling clock edge.
module tb_data_memory;
    logic clk;
    logic rst;

    data_memory_if bus ();

    data_memory #(
        .MEM_WORDS_LOG2(8),
        .INDEX_BITS    (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;   // 0: readData, 1: valid bit of line idx, 2: tag of line idx
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input string name, input int kind, input int idx,
                              input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [31:0] addr, input logic [31:0] wd,
                         input logic we, input logic re);
        @(posedge clk);
        #1;
        rst           = r;
        bus.address   = addr;
        bus.writeData = wd;
        bus.memWrite  = we;
        bus.memRead   = re;
    endtask

    // Monitor: compares every pending expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                0:       act = bus.readData;
                1:       act = {31'b0, dut.valid_q[e.idx]};
                default: act = {28'b0, dut.tag_q[e.idx]};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.address   = 32'h0;
        bus.writeData = 32'h0;
        bus.memWrite  = 1'b0;
        bus.memRead   = 1'b1;

        // Reset held: load returns zero and no line is valid
        drive(1'b1, 32'h000, 32'h0, 1'b0, 1'b1);
        expect_val("reset_rd",     0, 0,  32'h0);
        expect_val("reset_valid0", 1, 0,  32'h0);
        expect_val("reset_valid5", 1, 5,  32'h0);
        expect_val("reset_valid15",1, 15, 32'h0);

        // Store then load same address
        drive(1'b0, 32'h000, 32'hF0F0F0F0, 1'b1, 1'b0);
        expect_val("store_rd_off", 0, 0, 32'h0);
        drive(1'b0, 32'h000, 32'h0, 1'b0, 1'b1);
        expect_val("load_000",   0, 0, 32'hF0F0F0F0);
        expect_val("line0_valid",1, 0, 32'h1);
        expect_val("line0_tag0", 2, 0, 32'h0);

        // Conflicting store to index 0, tag 4
        drive(1'b0, 32'h100, 32'h00000001, 1'b1, 1'b0);
        drive(1'b0, 32'h100, 32'h0, 1'b0, 1'b1);
        expect_val("load_100",   0, 0, 32'h00000001);
        expect_val("line0_tag4", 2, 0, 32'h4);
        expect_val("line0_vld2", 1, 0, 32'h1);

        // Miss on evicted address reads through RAM, refills at the edge
        drive(1'b0, 32'h000, 32'h0, 1'b0, 1'b1);
        expect_val("miss_000",      0, 0, 32'hF0F0F0F0);
        expect_val("pre_refill_tag",2, 0, 32'h4);
        drive(1'b0, 32'h000, 32'h0, 1'b0, 1'b1);
        expect_val("refill_tag0",   2, 0, 32'h0);
        expect_val("hit_000",       0, 0, 32'hF0F0F0F0);

        // Read disabled
        drive(1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
        expect_val("rd_off_100", 0, 0, 32'h0);
        drive(1'b0, 32'h000, 32'h0, 1'b0, 1'b0);
        expect_val("rd_off_000", 0, 0, 32'h0);

        // Simultaneous read and write: old data before the edge, new after
        drive(1'b0, 32'h004, 32'hDEADBEEF, 1'b1, 1'b1);
        expect_val("rw_old", 0, 0, 32'h0);
        drive(1'b0, 32'h004, 32'h0, 1'b0, 1'b1);
        expect_val("rw_new",      0, 0, 32'hDEADBEEF);
        expect_val("line1_valid", 1, 1, 32'h1);
        expect_val("line1_tag0",  2, 1, 32'h0);

        // Aliasing modulo 1 KiB and ignored byte offset
        drive(1'b0, 32'h408, 32'h12345678, 1'b1, 1'b0);
        drive(1'b0, 32'h008, 32'h0, 1'b0, 1'b1);
        expect_val("alias_008", 0, 0, 32'h12345678);
        drive(1'b0, 32'h00B, 32'h0, 1'b0, 1'b1);
        expect_val("byteoff_00B", 0, 0, 32'h12345678);

        // Reset mid-run clears RAM and cache immediately
        drive(1'b1, 32'h008, 32'h0, 1'b0, 1'b1);
        expect_val("midrst_rd",     0, 0, 32'h0);
        expect_val("midrst_valid2", 1, 2, 32'h0);
        drive(1'b0, 32'h008, 32'h0, 1'b0, 1'b1);
        expect_val("post_rst_008", 0, 0, 32'h0);
        drive(1'b0, 32'h004, 32'h0, 1'b0, 1'b1);
        expect_val("post_rst_004", 0, 0, 32'h0);

        // Drain the scoreboard with a bounded wait
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data memory for the MIPS datapath, used in the memory stage.
- Consists of a backing RAM with a small direct-mapped, write-through, write-allocate cache in front of it.
- The cache is functionally transparent: every read returns the latest written data, with no stall signal.
- Cache state is internal and exists to support hit/miss and refill behaviour that verification can observe through hierarchy.

Parameters:
- MEM_WORDS_LOG2, 8, backing RAM depth = 2^8 = 256 x 32-bit words.
- INDEX_BITS, 4, cache depth = 16 lines of one 32-bit word each.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- address  input  32  byte address. Bits [1:0] are ignored. Word index = address[MEM_WORDS_LOG2+1:2]. Upper bits are ignored, so addresses alias modulo 1 KiB.
- writeData  input  32  store data.
- memWrite  input  1  write enable, sampled at the rising edge.
- memRead  input  1  read enable.
- readData  output  32  load data (combinational).

Behaviour:
- Address split:
  - word index w = address[9:2]
  - cache index i = address[5:2]
  - tag t = address[9:6]
- Cache line state: valid bit, 4-bit tag, 32-bit data.
- Reset: while rst=1 (asynchronous, takes effect immediately):
  - all cache valid bits cleared;
  - all backing RAM words set to 0;
  - readData = 0.
  - Writes and refills are blocked while rst=1.
  - Reset asserted mid-operation discards any pending write or refill at that edge.
- Hit: valid[i]=1 and tag[i]==t.
- readData (combinational):
  - memRead=0: readData = 0.
  - memRead=1 and hit: readData = cache data[i].
  - memRead=1 and miss: readData = RAM[w] (read-through, zero wait states).
- Write (rising edge, memWrite=1, rst=0):
  - RAM[w] <= writeData (write-through);
  - line i <= {valid=1, tag=t, data=writeData} (write-allocate, overwrites any conflicting line).
- Read refill (rising edge, memRead=1, memWrite=0, rst=0, miss): line i <= {1, t, RAM[w]}.
- Read hit: no state change.
- memRead and memWrite both high:
  - readData shows the pre-edge value (old data);
  - the write applies at the edge;
  - the write takes priority over refill.
- Coherence: since the cache is write-through, RAM always holds current data. Evictions need no writeback.
- Latency: loads are 0-cycle combinational. Stores are visible from the cycle after the edge.
- No X propagation: readData is never X after reset.

Test Plan:
- Reset: pulse rst with memRead=1, address=0x0 -> readData=0x00000000 immediately; all valid bits = 0.
- Store/load same address:
  - write 0xF0F0F0F0 @0x000, drop memWrite, then memRead=1 @0x000 -> readData=0xF0F0F0F0;
  - line 0 valid with tag 0 (hit).
- Conflict eviction:
  - after the previous step, write 0x00000001 @0x100 (same index 0, tag 4) -> line 0 tag=4;
  - read @0x100 -> 0x00000001 (hit);
  - read @0x000 -> 0xF0F0F0F0 from RAM (miss), and line 0 refilled with tag 0 at the next edge.
- Read disable: memRead=0 with any address -> readData=0.
- Simultaneous read and write @0x004 (old value 0), writeData=0xDEADBEEF -> readData=0 before the edge, 0xDEADBEEF after the edge.
- Aliasing/reset mid-run:
  - write 0x12345678 @0x408 -> read @0x008 returns 0x12345678;
  - then assert rst -> read @0x008 returns 0.
